// File: rtl/xbar_switch_pkg.sv
// xbar_pkg -- shared definitions for the xbar_switch crossbar.
//   Default parameter constants, the port-index type, the packet record
//   carried through the switch, and a small wrap-around index helper.
package xbar_pkg;

    localparam int DEF_NUM_PORTS  = 4;
    localparam int DEF_DATA_W     = 4;
    localparam int DEF_ADDR_W     = 4;
    localparam int DEF_FIFO_DEPTH = 4;

    typedef logic [DEF_ADDR_W-1:0] port_idx_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] data;
        port_idx_t             src;
        port_idx_t             dest;
    } pkt_t;

    // Next index after idx in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/xbar_switch_arbiter.sv
// xbar_rr_arbiter -- round-robin arbiter, one instance per crossbar output.
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset (pointer returns to input 0)
//   req    : NUM_PORTS request lines
//   grant  : one-hot grant, combinational from req and the pointer register
// After granting input k the highest priority moves to input k+1 (mod
// NUM_PORTS); the pointer holds when nothing is granted.
module xbar_rr_arbiter
    import xbar_pkg::*;
#(
    parameter int NUM_PORTS = DEF_NUM_PORTS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] grant
);

    localparam int PTR_W = $clog2(NUM_PORTS);

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] next_ptr_s;
    logic             found_s;

    // Scan from the pointer up to the top, then wrap to the inputs below it.
    always_comb begin
        grant      = '0;
        next_ptr_s = ptr_r;
        found_s    = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found_s && req[i] && (i >= int'(ptr_r))) begin
                grant[i]   = 1'b1;
                next_ptr_s = PTR_W'(wrap_inc(i, NUM_PORTS));
                found_s    = 1'b1;
            end else begin
                next_ptr_s = next_ptr_s;
            end
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found_s && req[i] && (i < int'(ptr_r))) begin
                grant[i]   = 1'b1;
                next_ptr_s = PTR_W'(wrap_inc(i, NUM_PORTS));
                found_s    = 1'b1;
            end else begin
                next_ptr_s = next_ptr_s;
            end
        end
    end

    // Priority pointer moves only when a grant is issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_r <= '0;
        end else if (found_s) begin
            ptr_r <= next_ptr_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/xbar_switch.sv
// xbar_switch -- NUM_PORTS x NUM_PORTS packet crossbar with output FIFOs.
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   data_in   : payload per input (slice i)
//   addr_in   : destination output index per input
//   valid_in  : input i presents a packet
//   rcv_rdy   : input i can accept a packet this cycle
//   data_out  : head-of-FIFO payload per output, 0 when empty
//   addr_out  : source index of the head packet, 0 when empty
//   data_read : consumer pops output j
//   data_rdy  : output j FIFO non-empty
//   drop_cnt  : (only with XBAR_SWITCH_DROP_CNT_EN) saturating count of
//               packets discarded for an out-of-range destination
// Each input owns one holding register; each output has a round-robin
// arbiter over the holding registers addressed to it and a FIFO of
// FIFO_DEPTH entries. A holding register that is granted frees on the same
// edge it moves into the FIFO, so an uncontended input streams one packet
// per cycle.
module xbar_switch
    import xbar_pkg::*;
#(
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS*DATA_W-1:0] data_in,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr_in,
    input  logic [NUM_PORTS-1:0]        valid_in,
    output logic [NUM_PORTS-1:0]        rcv_rdy,
    output logic [NUM_PORTS*DATA_W-1:0] data_out,
    output logic [NUM_PORTS*ADDR_W-1:0] addr_out,
    input  logic [NUM_PORTS-1:0]        data_read,
    output logic [NUM_PORTS-1:0]        data_rdy
`ifdef XBAR_SWITCH_DROP_CNT_EN
    ,
    output logic [15:0]                 drop_cnt
`endif
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = DATA_W + ADDR_W;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] src;
        logic [ADDR_W-1:0] dest;
    } hold_t;

    hold_t                hold_r [NUM_PORTS];
    logic [NUM_PORTS-1:0] hold_vld_r;
    logic [NUM_PORTS-1:0] grant_s [NUM_PORTS];   // grant_s[output][input]
    logic [NUM_PORTS-1:0] freed_s;
    logic [NUM_PORTS-1:0] accept_s;
    logic [NUM_PORTS-1:0] in_range_s;

    // An input's holding register is freed if any output granted it.
    always_comb begin
        freed_s = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            freed_s = freed_s | grant_s[j];
        end
    end

    assign rcv_rdy  = ~hold_vld_r | freed_s;
    assign accept_s = valid_in & rcv_rdy;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
        assign in_range_s[i] = 32'(addr_in[i*ADDR_W +: ADDR_W]) < NUM_PORTS;
    end

    // Holding registers: load on transfer (out-of-range packets leave it
    // empty, which is the discard), clear when granted, otherwise hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_vld_r <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                hold_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (accept_s[i]) begin
                    hold_vld_r[i]  <= in_range_s[i];
                    hold_r[i].data <= data_in[i*DATA_W +: DATA_W];
                    hold_r[i].src  <= ADDR_W'(i);
                    hold_r[i].dest <= addr_in[i*ADDR_W +: ADDR_W];
                end else if (freed_s[i]) begin
                    hold_vld_r[i]  <= 1'b0;
                end else begin
                    hold_vld_r[i]  <= hold_vld_r[i];
                end
            end
        end
    end

    for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out
        logic [NUM_PORTS-1:0] req;
        logic [ENTRY_W-1:0]   push_entry;
        logic                 push;
        logic                 pop;
        logic                 full;
        logic [PTR_W-1:0]     wr_ptr_r;
        logic [PTR_W-1:0]     rd_ptr_r;
        logic [CNT_W-1:0]     cnt_r;
        logic [ENTRY_W-1:0]   mem_r [FIFO_DEPTH];

        assign full = (cnt_r == CNT_W'(FIFO_DEPTH));
        assign push = |grant_s[j];
        assign pop  = data_read[j] && (cnt_r != '0);

        // A full FIFO requests nothing, even if it is being popped now.
        always_comb begin
            req = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                req[i] = hold_vld_r[i] && (hold_r[i].dest == ADDR_W'(j)) && !full;
            end
        end

        xbar_rr_arbiter #(
            .NUM_PORTS (NUM_PORTS)
        ) u_arb (
            .clk   (clk),
            .reset (reset),
            .req   (req),
            .grant (grant_s[j])
        );

        // One-hot grant selects the holding register to push.
        always_comb begin
            push_entry = '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                push_entry = push_entry |
                    ({ENTRY_W{grant_s[j][i]}} & {hold_r[i].data, hold_r[i].src});
            end
        end

        // FIFO storage; occupancy is tracked by count so full and empty
        // are distinct even though the pointers coincide in both.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
                cnt_r    <= '0;
                for (int k = 0; k < FIFO_DEPTH; k++) begin
                    mem_r[k] <= '0;
                end
            end else begin
                if (push) begin
                    mem_r[wr_ptr_r] <= push_entry;
                    wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr_r <= rd_ptr_r + PTR_W'(1);
                end
                case ({push, pop})
                    2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                    2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                    default: cnt_r <= cnt_r;
                endcase
            end
        end

        assign data_rdy[j] = (cnt_r != '0);
        assign data_out[j*DATA_W +: DATA_W] =
            data_rdy[j] ? mem_r[rd_ptr_r][ENTRY_W-1 -: DATA_W] : '0;
        assign addr_out[j*ADDR_W +: ADDR_W] =
            data_rdy[j] ? mem_r[rd_ptr_r][ADDR_W-1:0] : '0;
    end

`ifdef XBAR_SWITCH_DROP_CNT_EN
    logic [NUM_PORTS-1:0] drop_s;
    logic [16:0]          drop_sum_s;

    assign drop_s     = accept_s & ~in_range_s;
    assign drop_sum_s = {1'b0, drop_cnt} + 17'($countones(drop_s));

    // Several inputs may drop in one cycle; saturate at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt <= 16'h0000;
        end else if (drop_sum_s[16]) begin
            drop_cnt <= 16'hFFFF;
        end else begin
            drop_cnt <= drop_sum_s[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_xbar_switch.sv
// tb_xbar_switch -- directed self-checking bench for xbar_switch with the
// default parameters (4 ports, 4-bit data and address, 4-deep FIFOs).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_xbar_switch;

    localparam int NP = 4;
    localparam int DW = 4;
    localparam int AW = 4;

    logic             clk;
    logic             reset;
    logic [NP*DW-1:0] data_in;
    logic [NP*AW-1:0] addr_in;
    logic [NP-1:0]    valid_in;
    logic [NP-1:0]    rcv_rdy;
    logic [NP*DW-1:0] data_out;
    logic [NP*AW-1:0] addr_out;
    logic [NP-1:0]    data_read;
    logic [NP-1:0]    data_rdy;
`ifdef XBAR_SWITCH_DROP_CNT_EN
    logic [15:0]      drop_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    xbar_switch #(
        .NUM_PORTS  (NP),
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .addr_in   (addr_in),
        .valid_in  (valid_in),
        .rcv_rdy   (rcv_rdy),
        .data_out  (data_out),
        .addr_out  (addr_out),
        .data_read (data_read),
        .data_rdy  (data_rdy)
`ifdef XBAR_SWITCH_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input int i, input logic [DW-1:0] d, input logic [AW-1:0] a);
        valid_in[i]           = 1'b1;
        data_in[i*DW +: DW]   = d;
        addr_in[i*AW +: AW]   = a;
    endtask

    function automatic logic [DW-1:0] dout(input int j);
        return data_out[j*DW +: DW];
    endfunction

    function automatic logic [AW-1:0] aout(input int j);
        return addr_out[j*AW +: AW];
    endfunction

    initial begin
        int got;
        logic acc6;

        reset     = 1'b0;
        data_in   = '0;
        addr_in   = '0;
        valid_in  = '0;
        data_read = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_rcv_rdy", 32'(rcv_rdy), 32'hF);
        check("rst_data_rdy", 32'(data_rdy), 32'h0);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_addr_out", 32'(addr_out), 32'h0);
`ifdef XBAR_SWITCH_DROP_CNT_EN
        check("rst_drop_cnt", 32'(drop_cnt), 32'h0);
`endif
        reset = 1'b1;
        tick();

        // Single packet: input 0 -> output 2, visible two edges later
        offer(0, 4'hA, 4'd2);
        tick();
        valid_in = '0;
        check("single_not_yet", 32'(data_rdy), 32'h0);
        tick();
        check("single_rdy", 32'(data_rdy), 32'b0100);
        check("single_data", 32'(dout(2)), 32'hA);
        check("single_src", 32'(aout(2)), 32'h0);
        data_read[2] = 1'b1;
        tick();
        data_read = '0;
        check("single_popped", 32'(data_rdy), 32'h0);
        check("single_out_zero", 32'(data_out), 32'h0);

        // Read of an empty output is ignored
        data_read[2] = 1'b1;
        tick();
        data_read = '0;
        check("empty_read_rdy", 32'(data_rdy), 32'h0);
        check("empty_read_rcv", 32'(rcv_rdy), 32'hF);
        offer(3, 4'h5, 4'd2);
        tick();
        valid_in = '0;
        tick();
        check("after_empty_rdy", 32'(data_rdy), 32'b0100);
        check("after_empty_data", 32'(dout(2)), 32'h5);
        check("after_empty_src", 32'(aout(2)), 32'h3);
        data_read[2] = 1'b1;
        tick();
        data_read = '0;
        check("after_empty_pop", 32'(data_rdy), 32'h0);

        // Contention: all inputs to output 1, two rounds
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NP; i++) offer(i, DW'(4 * r + i + 1), 4'd1);
            tick();
            valid_in = '0;
            check("cont_rcv_rdy", 32'(rcv_rdy), 32'b0001);
            tick();
            check("cont_first_rdy", 32'(data_rdy), 32'b0010);
            repeat (3) tick();
            for (int k = 0; k < NP; k++) begin
                check("cont_data", 32'(dout(1)), 32'(4 * r + k + 1));
                check("cont_src", 32'(aout(1)), 32'(k));
                data_read[1] = 1'b1;
                tick();
                data_read = '0;
            end
            check("cont_drained", 32'(data_rdy), 32'h0);
        end

        // Backpressure: six packets from input 1 to output 3, no reads
        for (int k = 1; k <= 5; k++) begin
            offer(1, DW'(k), 4'd3);
            check("bp_accept_rdy", 32'(rcv_rdy[1]), 32'h1);
            tick();
        end
        offer(1, 4'd6, 4'd3);
        check("bp_stall", 32'(rcv_rdy[1]), 32'h0);
        check("bp_out_rdy", 32'(data_rdy), 32'b1000);
        tick();
        check("bp_stall_hold", 32'(rcv_rdy[1]), 32'h0);
        check("bp_head", 32'(dout(3)), 32'h1);
        data_read[3] = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 6; c++) begin
            if (data_rdy[3]) begin
                check("bp_data", 32'(dout(3)), 32'(got + 1));
                check("bp_src", 32'(aout(3)), 32'h1);
                got++;
            end
            acc6 = valid_in[1] && rcv_rdy[1];
            tick();
            if (acc6) valid_in[1] = 1'b0;
        end
        data_read = '0;
        check("bp_count", 32'(got), 32'd6);
        check("bp_drained", 32'(data_rdy), 32'h0);
        valid_in = '0;

        // Out-of-range destination is discarded
        offer(2, 4'h9, 4'h7);
        tick();
        valid_in = '0;
        check("drop_rcv_rdy", 32'(rcv_rdy), 32'hF);
        tick();
        check("drop_no_rdy", 32'(data_rdy), 32'h0);
        tick();
        check("drop_no_rdy_late", 32'(data_rdy), 32'h0);
`ifdef XBAR_SWITCH_DROP_CNT_EN
        check("drop_cnt", 32'(drop_cnt), 32'h1);
`endif

        // Reset mid-operation: three queued at output 0, one still held
        for (int i = 0; i < NP; i++) offer(i, DW'(7 + i), 4'd0);
        tick();
        valid_in = '0;
        repeat (3) tick();
        check("mid_queued", 32'(data_rdy), 32'b0001);
        check("mid_head", 32'(dout(0)), 32'h7);
        reset = 1'b0;
        #2;
        check("mid_rst_rdy", 32'(data_rdy), 32'h0);
        check("mid_rst_rcv", 32'(rcv_rdy), 32'hF);
        check("mid_rst_out", 32'(data_out), 32'h0);
        #2;
        reset = 1'b1;
        data_read[0] = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check("mid_nothing", 32'(data_rdy), 32'h0);
        end
        data_read = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
